uart_rx_path: RTL and testbench

UART receiver for 8N1 serial frames, LSB first, at a fixed baud rate set by a clock-divider parameter. Synchronises the asynchronous `uart_rx_i` pin, validates the start bit at mid-bit, samples the data bits at their centres and checks the stop bit. Each good byte is presented as a one-cycle `uart_rx_done_o` strobe with the data held stable. It sits at the serial input pin, opposite the team's UART transmit path, and shares its `BAUD_DIV` convention so both ends run at the same rate.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx_path.sv | 105 ++++++++++
 tb/tb_uart_rx_path.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame width and the default baud divider
// (kept identical to the transmit path's so both ends agree on the rate).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam int unsigned UART_DATA_BITS        = 8;
  localparam logic [13:0] UART_BAUD_DIV_DEFAULT = 14'd434;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial pin plus a falling-edge detector.
// All flops reset to the idle (high) line level so reset never fakes a start edge.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic rx_i,
  output logic level,
  output logic fall
);

  logic meta;
  logic sync;
  logic dly;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta <= 1'b1;
      sync <= 1'b1;
      dly  <= 1'b1;
    end else begin
      meta <= rx_i;
      sync <= meta;
      dly  <= sync;
    end
  end

  assign level = sync;
  assign fall  = dly & ~sync;

endmodule

// File: rtl/uart_rx_path.sv
// 8N1 UART receiver: validates the start bit at mid-bit, samples data bits at their
// centres, checks the stop bit and emits one-cycle done / frame-error strobes.
module uart_rx_path
  import uart_pkg::*;
#(
  parameter logic [13:0] BAUD_DIV = UART_BAUD_DIV_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      uart_rx_i,
  output logic [UART_DATA_BITS-1:0] uart_rx_data_o,
  output logic                      uart_rx_done_o,
  output logic                      uart_frame_err_o,
  output logic                      uart_busy
);

  localparam logic [13:0] HALF = BAUD_DIV >> 1;

  rx_state_e                 state;
  rx_state_e                 state_nxt;
  logic [13:0]               cnt;
  logic [2:0]                idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      rx_level;
  logic                      rx_fall;
  logic                      sample_pt;
  logic                      last_bit;
  logic                      done_nxt;
  logic                      err_nxt;

  uart_rx_sync u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .rx_i    (uart_rx_i),
    .level   (rx_level),
    .fall    (rx_fall)
  );

  // Start is checked at half a bit so every later sample lands at a bit centre.
  always_comb begin
    sample_pt = 1'b0;
    unique case (state)
      START:       sample_pt = (cnt == HALF);
      DATA, STOP:  sample_pt = (cnt == BAUD_DIV);
      default:     sample_pt = 1'b0;
    endcase
  end

  assign last_bit = (idx == 3'(UART_DATA_BITS - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (rx_fall)               state_nxt = START;
      START:     if (sample_pt)             state_nxt = rx_level ? IDLE : DATA;
      DATA:      if (sample_pt && last_bit) state_nxt = STOP;
      STOP:      if (sample_pt)             state_nxt = rx_level ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_level)              state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  always_comb begin
    uart_busy = (state != IDLE);
    done_nxt  = (state == STOP) && sample_pt && rx_level;
    err_nxt   = (state == STOP) && sample_pt && !rx_level;
  end

  // Counter only runs while timing a bit; everything else holds it at zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt              <= '0;
      idx              <= '0;
      shreg            <= '0;
      uart_rx_data_o   <= '0;
      uart_rx_done_o   <= 1'b0;
      uart_frame_err_o <= 1'b0;
    end else begin
      if (state_nxt != state || sample_pt || state == IDLE || state == WAIT_HIGH)
        cnt <= '0;
      else
        cnt <= cnt + 14'd1;

      if (state == START && state_nxt == DATA)
        idx <= '0;
      else if (state == DATA && sample_pt)
        idx <= idx + 3'd1;

      if (state == DATA && sample_pt)
        shreg <= {rx_level, shreg[UART_DATA_BITS-1:1]};

      if (done_nxt)
        uart_rx_data_o <= shreg;

      uart_rx_done_o   <= done_nxt;
      uart_frame_err_o <= err_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx_path.sv
// Directed bench for uart_rx_path: a BAUD_DIV=15 instance for the functional scenarios
// and a BAUD_DIV=99 instance for bit-period tolerance (97/100/103-cycle senders).
module tb_uart_rx_path;

  localparam logic [13:0] BD  = 14'd15;
  localparam logic [13:0] BDW = 14'd99;
  localparam int          P   = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       rx_w  = 1'b1;
  logic [7:0] data;
  logic       done;
  logic       err;
  logic       busy;
  logic [7:0] data_w;
  logic       done_w;
  logic       err_w;
  logic       busy_w;

  int checks = 0;
  int errors = 0;

  uart_rx_path #(.BAUD_DIV(BD)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .uart_rx_i        (rx),
    .uart_rx_data_o   (data),
    .uart_rx_done_o   (done),
    .uart_frame_err_o (err),
    .uart_busy        (busy)
  );

  uart_rx_path #(.BAUD_DIV(BDW)) dut_w (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .uart_rx_i        (rx_w),
    .uart_rx_data_o   (data_w),
    .uart_rx_done_o   (done_w),
    .uart_frame_err_o (err_w),
    .uart_busy        (busy_w)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          done_cnt = 0;
  int          err_cnt = 0;
  int          done_w_cnt = 0;
  int          err_w_cnt = 0;
  int unsigned last_done_cyc = 0;
  int unsigned prev_done_cyc = 0;
  bit          both_seen = 1'b0;
  logic [7:0]  rxq[$];
  logic [7:0]  rxq_w[$];

  always @(negedge clk) begin
    if (done) begin
      done_cnt      = done_cnt + 1;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      rxq.push_back(data);
    end
    if (err) err_cnt = err_cnt + 1;
    if (done && err) both_seen = 1'b1;
    if (done_w) begin
      done_w_cnt = done_w_cnt + 1;
      rxq_w.push_back(data_w);
    end
    if (err_w) err_w_cnt = err_w_cnt + 1;
    if (done_w && err_w) both_seen = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Line drivers change the pin 1 time unit after a rising edge.
  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rx_w = v;
    else     rx   = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input logic stopb, input int period);
    drive(sel, 1'b0, period);
    for (int i = 0; i < 8; i++) drive(sel, b[i], period);
    drive(sel, stopb, period);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0)   begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    int d0, e0;
    int unsigned t0, dt;
    align();
    drive(0, 1'b1, 2 * P);
    d0 = done_cnt; e0 = err_cnt;
    t0 = cyc;
    send_frame(0, 8'hA5, 1'b1, P);
    drive(0, 1'b1, P);
    dt = last_done_cyc - t0;
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_count got %0d want 1", done_cnt - d0); end
    checks++; if (data !== 8'hA5)     begin errors++; $display("FAIL single_data got %h want a5", data); end
    checks++; if (err_cnt != e0)      begin errors++; $display("FAIL single_err_count got %0d want 0", err_cnt - e0); end
    // Nominal 3 (sync) + 8 (start to mid-bit) + 9*16 (to stop sample) = 155 cycles.
    checks++; if (dt < 153 || dt > 157) begin errors++; $display("FAIL single_latency got %0d want 153..157", dt); end
  endtask

  task automatic test_back_to_back();
    int d0, n0;
    d0 = done_cnt; n0 = rxq.size();
    send_frame(0, 8'h00, 1'b1, P);
    send_frame(0, 8'hFF, 1'b1, P);
    drive(0, 1'b1, 2 * P);
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt - d0); end
    if (rxq.size() >= n0 + 2) begin
      checks++; if (rxq[n0] !== 8'h00)   begin errors++; $display("FAIL b2b_first got %h want 00", rxq[n0]); end
      checks++; if (rxq[n0+1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h want ff", rxq[n0+1]); end
      checks++; if (last_done_cyc - prev_done_cyc != 160)
        begin errors++; $display("FAIL b2b_spacing got %0d want 160", last_done_cyc - prev_done_cyc); end
    end else begin
      checks++; errors++; $display("FAIL b2b_queue got %0d bytes want 2", rxq.size() - n0);
    end
  endtask

  task automatic test_glitch();
    int d0, e0, hi;
    bit seen;
    d0 = done_cnt; e0 = err_cnt; hi = 0; seen = 1'b0;
    fork
      begin
        drive(0, 1'b0, 4);
        drive(0, 1'b1, 1);
      end
      begin
        repeat (30) begin
          @(negedge clk);
          if (busy) begin hi++; seen = 1'b1; end
        end
      end
    join
    align();
    checks++; if (!seen)              begin errors++; $display("FAIL glitch_busy_rise got 0 want 1"); end
    // START is held for HALF+1 = 8 cycles before the start sample rejects the glitch.
    checks++; if (hi != 8)            begin errors++; $display("FAIL glitch_busy_len got %0d want 8", hi); end
    checks++; if (done_cnt != d0 || err_cnt != e0)
      begin errors++; $display("FAIL glitch_strobes got %0d/%0d want 0/0", done_cnt - d0, err_cnt - e0); end
    checks++; if (data !== 8'hFF)     begin errors++; $display("FAIL glitch_data got %h want ff", data); end
  endtask

  task automatic test_frame_err();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(0, 8'h3C, 1'b0, P);
    drive(0, 1'b0, 40);
    drive(0, 1'b1, 2 * P);
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL ferr_err_count got %0d want 1", err_cnt - e0); end
    checks++; if (done_cnt != d0)    begin errors++; $display("FAIL ferr_done_count got %0d want 0", done_cnt - d0); end
    checks++; if (data !== 8'hFF)    begin errors++; $display("FAIL ferr_data_hold got %h want ff", data); end
    send_frame(0, 8'h81, 1'b1, P);
    drive(0, 1'b1, 2 * P);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ferr_next_done got %0d want 1", done_cnt - d0); end
    checks++; if (data !== 8'h81)     begin errors++; $display("FAIL ferr_next_data got %h want 81", data); end
    checks++; if (err_cnt - e0 != 1)  begin errors++; $display("FAIL ferr_err_total got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_reset_abort();
    int d0, e0;
    logic [7:0] b;
    b = 8'h55;
    d0 = done_cnt; e0 = err_cnt;
    drive(0, 1'b0, P);
    for (int i = 0; i < 4; i++) drive(0, b[i], P);
    drive(0, b[4], P / 2);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL abort_data got %h want 00", data); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0 || err !== 1'b0)
      begin errors++; $display("FAIL abort_strobes got %b%b want 00", done, err); end
    align();
    rst_n = 1'b1;
    drive(0, 1'b1, 3 * P);
    checks++; if (done_cnt != d0 || err_cnt != e0)
      begin errors++; $display("FAIL abort_no_strobe got %0d/%0d want 0/0", done_cnt - d0, err_cnt - e0); end
    send_frame(0, 8'h12, 1'b1, P);
    drive(0, 1'b1, 2 * P);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL abort_next_done got %0d want 1", done_cnt - d0); end
    checks++; if (data !== 8'h12)     begin errors++; $display("FAIL abort_next_data got %h want 12", data); end
  endtask

  task automatic test_tolerance();
    logic [7:0] tbl [8];
    int periods [3];
    int n0, e0;
    tbl = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h3C, 8'hC3};
    periods = '{100, 97, 103};
    for (int p = 0; p < 3; p++) begin
      n0 = rxq_w.size(); e0 = err_w_cnt;
      drive(1, 1'b1, 2 * periods[p]);
      for (int i = 0; i < 8; i++) send_frame(1, tbl[i], 1'b1, periods[p]);
      drive(1, 1'b1, 2 * periods[p]);
      checks++; if (err_w_cnt != e0)
        begin errors++; $display("FAIL tol_err period %0d got %0d want 0", periods[p], err_w_cnt - e0); end
      checks++; if (rxq_w.size() != n0 + 8) begin
        errors++; $display("FAIL tol_count period %0d got %0d want 8", periods[p], rxq_w.size() - n0);
      end else begin
        for (int i = 0; i < 8; i++) begin
          checks++; if (rxq_w[n0+i] !== tbl[i])
            begin errors++; $display("FAIL tol_byte period %0d idx %0d got %h want %h", periods[p], i, rxq_w[n0+i], tbl[i]); end
        end
      end
    end
  endtask

  task automatic test_exclusive();
    checks++; if (both_seen) begin errors++; $display("FAIL strobes_exclusive got 1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_abort();
    test_tolerance();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
